cordic_sched: RTL

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_result_fifo.sv | 63 ++++++
 rtl/cordic_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler.
//   cordic_latency() : register stages of the attached cordic (iterations+1)
//   cordic_res_t     : one buffered result {id, x, y, z}
// The result struct is sized for WIDTH = CORDIC_W and up to 8 requesters
// (CORDIC_ID_W bits of id). Narrower requester indices are zero-extended.
package cordic_pkg;

    localparam int CORDIC_ITER = 17;
    localparam int CORDIC_W    = 16;
    localparam int CORDIC_ID_W = 3;

    function automatic int cordic_latency(input int iterations);
        return iterations + 1;
    endfunction

    typedef struct packed {
        logic [CORDIC_ID_W-1:0]     id;
        logic signed [CORDIC_W:0]   x;
        logic signed [CORDIC_W:0]   y;
        logic signed [CORDIC_W-1:0] z;
    } cordic_res_t;

endpackage

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through result buffer for cordic_sched.
//   clk, reset : clock, synchronous active-high reset (clears pointers/count)
//   push_i     : write din_i this edge
//   pop_i      : consume the head this edge (ignored while empty)
//   dout_o     : head entry, valid whenever valid_o = 1
//   valid_o    : buffer non-empty
//   count_o    : current occupancy
module cordic_result_fifo #(
    parameter int DEPTH = 20,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [W-1:0]                 din_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 dout_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // A push into a full buffer is only legal when the head leaves on the same edge.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push_i |-> ((count_q < CW'(DEPTH)) || pop_i));

endmodule

// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one pipelined cordic among N_REQ requesters.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot or zero)
//   req_x/req_y/req_z     : per-requester operands
//   cx0/cy0/cz0           : registered operands to the cordic (0 when idle)
//   cx/cy/cz              : cordic results, LATENCY edges after cx0/cy0/cz0
//   res_valid/res_ready   : result handshake (first-word-fall-through)
//   res_id/res_x/res_y/res_z : head result and the requester that issued it
// WIDTH must equal cordic_pkg::CORDIC_W (the buffered result struct width).
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int WIDTH   = CORDIC_W,
    parameter int N_REQ   = 4,
    parameter int LATENCY = cordic_latency(CORDIC_ITER),
    parameter int DEPTH   = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic signed [WIDTH-1:0]    req_x [N_REQ],
    input  logic signed [WIDTH-1:0]    req_y [N_REQ],
    input  logic signed [WIDTH-1:0]    req_z [N_REQ],
    output logic signed [WIDTH-1:0]    cx0,
    output logic signed [WIDTH-1:0]    cy0,
    output logic signed [WIDTH-1:0]    cz0,
    input  logic signed [WIDTH:0]      cx,
    input  logic signed [WIDTH:0]      cy,
    input  logic signed [WIDTH-1:0]    cz,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic signed [WIDTH:0]      res_x,
    output logic signed [WIDTH:0]      res_y,
    output logic signed [WIDTH-1:0]    res_z
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int OW   = CW + 1;

    logic [ID_W-1:0] ptr_q, ptr_d, gnt_idx, idx;
    logic            found, credit_ok, accept, push, pop;
    logic [OW-1:0]   occ;
    logic [CW-1:0]   fifo_count, inflight_q, inflight_d;
    logic [LATENCY:0] tag_vld_q;
    logic [ID_W-1:0] tag_id_q [LATENCY+1];
    cordic_res_t     push_data, head;
    logic            unused_id_bits;

    always_comb begin
        // Credits use start-of-cycle occupancy; a pop this edge frees space next cycle.
        occ       = {1'b0, fifo_count} + {1'b0, inflight_q};
        credit_ok = occ < OW'(DEPTH);

        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end

        accept    = found && credit_ok && !reset;
        req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;

        ptr_d = ptr_q;
        if (accept) ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

        push = tag_vld_q[LATENCY];
        pop  = res_valid && res_ready;

        inflight_d = inflight_q;
        case ({accept, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        push_data.id = CORDIC_ID_W'(tag_id_q[LATENCY]);
        push_data.x  = cx;
        push_data.y  = cy;
        push_data.z  = cz;
    end

    // Stage: acceptance -> cordic operand registers and tag pipe entry
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            inflight_q <= '0;
            tag_vld_q  <= '0;
            cx0        <= '0;
            cy0        <= '0;
            cz0        <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            tag_vld_q  <= {tag_vld_q[LATENCY-1:0], accept};
            cx0        <= accept ? req_x[gnt_idx] : '0;
            cy0        <= accept ? req_y[gnt_idx] : '0;
            cz0        <= accept ? req_z[gnt_idx] : '0;
        end
    end

    // Tag ids ride alongside the cordic; a tag sits at index LATENCY in the
    // same cycle its operands' result is on cx/cy/cz.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_idx;
        for (int i = 1; i <= LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
    end

    // Stage: pipe exit -> result buffer
    cordic_result_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cordic_res_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (push_data),
        .pop_i   (pop),
        .dout_o  (head),
        .valid_o (res_valid),
        .count_o (fifo_count)
    );

    assign res_id         = head.id[ID_W-1:0];
    assign res_x          = head.x;
    assign res_y          = head.y;
    assign res_z          = head.z;
    assign unused_id_bits = ^head.id;

endmodule
